// File: rtl/shift_pkg.sv
// Shared definitions for the sequential shifter: op encodings, FSM states
// and the datapath width. Rotate support is enabled by SHIFT_SEQ_ROTATE_EN.
package shift_pkg;

    localparam int XLEN = 64;

    // op[1:0] encodings; op[OP_WORD_BIT] selects the 32-bit word form
    localparam logic [1:0] OP_SLL = 2'd0;
    localparam logic [1:0] OP_SRL = 2'd1;
    localparam logic [1:0] OP_SRA = 2'd2;
    localparam logic [1:0] OP_ROR = 2'd3;
    localparam int OP_WORD_BIT = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Word-form results are always sign-extended from bit 31
    function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
        return {{(XLEN-32){v[31]}}, v[31:0]};
    endfunction

endpackage

// File: rtl/shift_step.sv
// Single combinational shift step: moves the accumulator by 1 or STEP bits.
// Rotate mode (32- or 64-bit) exists only when SHIFT_SEQ_ROTATE_EN is defined.
module shift_step
    import shift_pkg::*;
#(
    parameter int STEP = 8
) (
    input  logic [XLEN-1:0] acc_i,
    input  logic            big_i,
    input  logic [1:0]      mode_i,
`ifdef SHIFT_SEQ_ROTATE_EN
    input  logic            word_i,
`endif
    output logic [XLEN-1:0] acc_o
);

    logic [6:0] amt;
`ifdef SHIFT_SEQ_ROTATE_EN
    logic [31:0] lo;
    logic [31:0] lo_rot;
`endif

    // Select the step size and apply one shift/rotate of that size
    always_comb begin
        amt   = big_i ? 7'(STEP) : 7'd1;
`ifdef SHIFT_SEQ_ROTATE_EN
        lo     = acc_i[31:0];
        lo_rot = (lo >> amt) | (lo << (7'd32 - amt));
`endif
        case (mode_i)
            OP_SRL:  acc_o = acc_i >> amt;
            OP_SRA:  acc_o = $unsigned($signed(acc_i) >>> amt);
`ifdef SHIFT_SEQ_ROTATE_EN
            // Word rotate keeps the upper half clear; sign extension happens
            // once, when the result is formed.
            OP_ROR:  acc_o = word_i ? {32'b0, lo_rot}
                                    : (acc_i >> amt) | (acc_i << (7'd64 - amt));
`endif
            default: acc_o = acc_i << amt;
        endcase
    end

endmodule

// File: rtl/shift_seq.sv
// Multi-cycle RV64 shift unit (SLL/SRL/SRA and word forms) with valid/ready
// on issue and writeback. Shifts up to STEP bits per cycle.
// Define SHIFT_SEQ_ROTATE_EN to turn op[1:0]==3 into ROR/RORW; otherwise
// that encoding behaves as SLL/SLLW.
module shift_seq
    import shift_pkg::*;
#(
    parameter int XLEN = 64,   // only 64 is supported
    parameter int STEP = 8     // power of two, 2..32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] in0,
    input  logic [XLEN-1:0] in1,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    state_t          state_q, state_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [5:0]      cnt_q, cnt_d;
    logic [1:0]      mode_q, mode_d;
    logic            word_q, word_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;

    logic            step_big;
    logic [5:0]      step_amt;
    logic [XLEN-1:0] step_acc;
    logic [5:0]      shamt;
    logic            unused_in1;

    // Only the low shift-amount bits of in1 matter
    assign unused_in1 = ^in1[XLEN-1:6];

    assign step_big = (cnt_q >= 6'(STEP));
    assign step_amt = step_big ? 6'(STEP) : 6'd1;

    shift_step #(.STEP(STEP)) u_step (
        .acc_i  (acc_q),
        .big_i  (step_big),
        .mode_i (mode_q),
`ifdef SHIFT_SEQ_ROTATE_EN
        .word_i (word_q),
`endif
        .acc_o  (step_acc)
    );

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        result_d    = result_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        word_d      = word_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        shamt       = 6'd0;

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q && !flush) begin
`ifdef SHIFT_SEQ_ROTATE_EN
                    mode_d = op[1:0];
`else
                    mode_d = (op[1:0] == OP_ROR) ? OP_SLL : op[1:0];
`endif
                    word_d = op[OP_WORD_BIT];
                    shamt  = word_d ? {1'b0, in1[4:0]} : in1[5:0];
                    if (!word_d)
                        acc_d = in0;
                    else if (mode_d == OP_SRA)
                        acc_d = sext32(in0);
                    else
                        acc_d = {{(XLEN-32){1'b0}}, in0[31:0]};
                    cnt_d      = shamt;
                    in_ready_d = 1'b0;
                    if (shamt == 6'd0) begin
                        state_d     = ST_DONE;
                        out_valid_d = 1'b1;
                        result_d    = word_d ? sext32(acc_d) : acc_d;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                acc_d = step_acc;
                cnt_d = cnt_q - step_amt;
                if (cnt_d == 6'd0) begin
                    state_d     = ST_DONE;
                    out_valid_d = 1'b1;
                    result_d    = word_q ? sext32(step_acc) : step_acc;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase

        // Flush wins over everything: drop the op and return to IDLE
        if (flush) begin
            state_d     = ST_IDLE;
            cnt_d       = 6'd0;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
        end
    end

    // State and output registers; reset returns immediately to IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            result_q    <= '0;
            cnt_q       <= '0;
            mode_q      <= OP_SLL;
            word_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            word_q      <= word_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule

// File: tb/tb_shift_seq.sv
// Self-checking bench for shift_seq: scoreboard of expected result/latency
// pushed at issue and popped when out_valid appears. Rotate expectations
// follow SHIFT_SEQ_ROTATE_EN.
module tb_shift_seq;

    localparam int STEP = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, flush, out_valid, out_ready;
    logic [2:0]  op;
    logic [63:0] in0, in1, result;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [63:0] res;
        int          lat;
    } exp_t;
    exp_t sb[$];

    shift_seq #(.XLEN(64), .STEP(STEP)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .in0       (in0),
        .in1       (in1),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    always #5 clk = ~clk;

    // Reference: native full-width shifts, no stepping
    function automatic logic [63:0] ref_res(input logic [2:0] o, input logic [63:0] a,
                                            input logic [63:0] b);
        logic [1:0]  k;
        logic [31:0] lo, r32;
        int          s;
        k = o[1:0];
`ifndef SHIFT_SEQ_ROTATE_EN
        if (k == 2'd3) k = 2'd0;
`endif
        if (!o[2]) begin
            s = int'(b[5:0]);
            case (k)
                2'd0: return a << s;
                2'd1: return a >> s;
                2'd2: return $unsigned($signed(a) >>> s);
                default: return (a >> s) | (a << (64 - s));
            endcase
        end
        s  = int'(b[4:0]);
        lo = a[31:0];
        case (k)
            2'd0: r32 = lo << s;
            2'd1: r32 = lo >> s;
            2'd2: r32 = $unsigned($signed(lo) >>> s);
            default: r32 = (lo >> s) | (lo << (32 - s));
        endcase
        return {{32{r32[31]}}, r32};
    endfunction

    function automatic int ref_lat(input logic [2:0] o, input logic [63:0] b);
        int s;
        s = o[2] ? int'(b[4:0]) : int'(b[5:0]);
        return s / STEP + s % STEP + 1;
    endfunction

    // Issue one op from IDLE (called at posedge+1); returns at accept edge+1
    task automatic send(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b,
                        input bit push);
        op = o; in0 = a; in1 = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (push) sb.push_back('{ref_res(o, a, b), ref_lat(o, b)});
    endtask

    // Count edges from the accept edge until out_valid; -1 on timeout
    task automatic wait_out(output int lat);
        lat = 1;
        while (out_valid !== 1'b1) begin
            if (lat >= 200) begin
                lat = -1;
                break;
            end
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // Issue, wait, capture and retire one op (out_ready assumed high)
    task automatic do_op(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] res, output int lat, output exp_t e);
        send(o, a, b, 1'b1);
        wait_out(lat);
        res = result;
        e   = sb.pop_front();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        op = 3'd0; in0 = '0; in1 = '0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_state in_ready=%b out_valid=%b result=%h exp 1/0/0",
                     in_ready, out_valid, result);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset in_ready=%b out_valid=%b", in_ready, out_valid);
        end
    endtask

    task automatic test_sll();
        logic [63:0] r; int lat; exp_t e;
        do_op(3'd0, 64'h1, 64'd63, r, lat, e);
        n_tests++;
        if (lat != 15 || lat != e.lat) begin
            n_fail++;
            $display("FAIL sll63_latency got=%0d exp=15", lat);
        end
        n_tests++;
        if (r !== 64'h8000_0000_0000_0000) begin
            n_fail++;
            $display("FAIL sll63_result got=%h exp=8000000000000000", r);
        end
    endtask

    task automatic test_sra_srl();
        logic [2:0]  ops [2] = '{3'd2, 3'd1};
        logic [63:0] want[2] = '{64'hF800_0000_0000_0000, 64'h0800_0000_0000_0000};
        logic [63:0] r; int lat; exp_t e;
        for (int i = 0; i < 2; i++) begin
            do_op(ops[i], 64'h8000_0000_0000_0000, 64'd4, r, lat, e);
            n_tests++;
            if (r !== want[i] || r !== e.res) begin
                n_fail++;
                $display("FAIL sra_srl_result op=%0d got=%h exp=%h", ops[i], r, want[i]);
            end
            n_tests++;
            if (lat != 5 || lat != e.lat) begin
                n_fail++;
                $display("FAIL sra_srl_latency op=%0d got=%0d exp=5", ops[i], lat);
            end
        end
    endtask

    task automatic test_word();
        logic [2:0]  ops [3] = '{3'd6, 3'd5, 3'd4};
        logic [63:0] a   [3] = '{64'h8000_0000, 64'h8000_0000, 64'h1};
        logic [63:0] b   [3] = '{64'h21, 64'h1, 64'd31};
        logic [63:0] want[3] = '{64'hFFFF_FFFF_C000_0000, 64'h0000_0000_4000_0000,
                                 64'hFFFF_FFFF_8000_0000};
        logic [63:0] r; int lat; exp_t e;
        for (int i = 0; i < 3; i++) begin
            do_op(ops[i], a[i], b[i], r, lat, e);
            n_tests++;
            if (r !== want[i] || r !== e.res) begin
                n_fail++;
                $display("FAIL word_result op=%0d got=%h exp=%h", ops[i], r, want[i]);
            end
            n_tests++;
            if (lat != e.lat) begin
                n_fail++;
                $display("FAIL word_latency op=%0d got=%0d exp=%0d", ops[i], lat, e.lat);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat; exp_t e;
        out_ready = 1'b0;
        send(3'd1, 64'hDEAD, 64'd0, 1'b1);
        wait_out(lat);
        e = sb.pop_front();
        n_tests++;
        if (lat != 1 || result !== e.res) begin
            n_fail++;
            $display("FAIL bp_first lat=%0d result=%h exp lat=1 result=%h", lat, result, e.res);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_tests++;
            if (out_valid !== 1'b1 || result !== 64'hDEAD || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold cyc=%0d out_valid=%b result=%h in_ready=%b exp 1/dead/0",
                         i, out_valid, result, in_ready);
            end
        end
        out_ready = 1'b1;
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_ready_early in_ready=%b exp=0", in_ready);
        end
        @(posedge clk); #1;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_flush();
        bit seen; logic [63:0] r; int lat; exp_t e;
        send(3'd0, 64'h1, 64'd40, 1'b0);      // first SHIFT cycle
        repeat (2) begin @(posedge clk); #1; end
        flush = 1'b1;                          // third SHIFT cycle
        @(posedge clk); #1;
        flush = 1'b0;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_idle in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
        end
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        n_tests++;
        if (seen) begin
            n_fail++;
            $display("FAIL flush_dropped out_valid seen=1 exp=0");
        end
        // in_valid together with flush must not be accepted
        op = 3'd1; in0 = 64'h5; in1 = 64'd0; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_no_accept in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
        end
        do_op(3'd2, 64'h8000_0000_0000_0000, 64'd4, r, lat, e);
        n_tests++;
        if (r !== 64'hF800_0000_0000_0000 || lat != e.lat) begin
            n_fail++;
            $display("FAIL flush_followup result=%h lat=%0d exp=f800000000000000 lat=%0d",
                     r, lat, e.lat);
        end
    endtask

    task automatic test_rst_mid();
        send(3'd0, 64'h1, 64'd40, 1'b0);
        @(posedge clk); #1;
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || result !== 64'd0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_async out_valid=%b result=%h in_ready=%b exp 0/0/1",
                     out_valid, result, in_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_rotate();
`ifdef SHIFT_SEQ_ROTATE_EN
        logic [63:0] want[2] = '{64'h8000_0000_0000_0000, 64'hFFFF_FFFF_8000_0000};
`else
        logic [63:0] want[2] = '{64'h2, 64'h2};
`endif
        logic [2:0]  ops [2] = '{3'd3, 3'd7};
        logic [63:0] r; int lat; exp_t e;
        for (int i = 0; i < 2; i++) begin
            do_op(ops[i], 64'h1, 64'h1, r, lat, e);
            n_tests++;
            if (r !== want[i] || r !== e.res || lat != 2) begin
                n_fail++;
                $display("FAIL op3_result op=%0d got=%h lat=%0d exp=%h lat=2",
                         ops[i], r, lat, want[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] r, a, b; logic [2:0] o; int lat; exp_t e;
        for (int i = 0; i < 24; i++) begin
            o = 3'($urandom_range(0, 7));
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            do_op(o, a, b, r, lat, e);
            n_tests++;
            if (r !== e.res) begin
                n_fail++;
                $display("FAIL rand_result i=%0d op=%0d a=%h b=%h got=%h exp=%h",
                         i, o, a, b, r, e.res);
            end
            n_tests++;
            if (lat != e.lat) begin
                n_fail++;
                $display("FAIL rand_latency i=%0d op=%0d got=%0d exp=%0d", i, o, lat, e.lat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sll();
        test_sra_srl();
        test_word();
        test_backpressure();
        test_flush();
        test_rst_mid();
        test_rotate();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
